// File: rtl/mips_pkg.sv
// Shared MIPS definitions: multiply/divide unit op encodings and FSM states.
package mips_pkg;

    typedef enum logic [1:0] {
        MDU_MUL  = 2'b00,
        MDU_DIV  = 2'b01,
        MDU_MTHI = 2'b10,
        MDU_MTLO = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_hilo_if.sv
// Execute-stage <-> MDU bundle: issue fields, flush, status and HI/LO outputs.
interface mdu_hilo_if #(
    parameter int WIDTH = 32
);
    import mips_pkg::*;

    logic             start;
    mdu_op_e          op;
    logic             sign;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, sign, src_a, src_b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, sign, src_a, src_b, flush,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mdu_divider.sv
// Unsigned restoring divider datapath; one quotient bit per step, sequenced by mdu_hilo.
module mdu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Dividend bits shift out of the top of quo_q as quotient bits shift in at the bottom.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        rem_d   = rem_q;
        quo_d   = quo_q;
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
        end else if (step) begin
            rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with HI/LO registers.
// Define MDU_FAST_MUL_EN for a single-cycle multiplier (MUL skips RUN).
module mdu_hilo
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    mdu_hilo_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = 2 * WIDTH;

    mdu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] a_mag_q, a_mag_d;
    logic [WIDTH-1:0] b_mag_q, b_mag_d;
    logic [WIDTH-1:0] raw_a_q, raw_a_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifndef MDU_FAST_MUL_EN
    logic [PW-1:0]    prod_q, prod_d;
    logic [WIDTH:0]   psum;
`endif

    logic             issue, a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH-1:0] quo, rem;
    logic [PW-1:0]    mul_mag, mul_res;

    assign issue = bus.start && !bus.flush && (state_q == MDU_IDLE);
    assign a_neg = bus.sign && bus.src_a[WIDTH-1];
    assign b_neg = bus.sign && bus.src_b[WIDTH-1];
    assign a_abs = a_neg ? ('0 - bus.src_a) : bus.src_a;
    assign b_abs = b_neg ? ('0 - bus.src_b) : bus.src_b;

    mdu_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (issue && (bus.op == MDU_DIV)),
        .step      ((state_q == MDU_RUN) && is_div_q),
        .dividend  (a_abs),
        .divisor   (b_mag_q),
        .quotient  (quo),
        .remainder (rem)
    );

    always_comb begin
`ifdef MDU_FAST_MUL_EN
        mul_mag = PW'(a_mag_q) * PW'(b_mag_q);
`else
        mul_mag = prod_q;
        psum    = {1'b0, prod_q[PW-1:WIDTH]} + (prod_q[0] ? {1'b0, a_mag_q} : '0);
        prod_d  = prod_q;
        if (issue && (bus.op == MDU_MUL))
            prod_d = {{WIDTH{1'b0}}, b_abs};
        else if ((state_q == MDU_RUN) && !is_div_q)
            prod_d = {psum, prod_q[WIDTH-1:1]};
`endif
        mul_res = neg_q ? ('0 - mul_mag) : mul_mag;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        raw_a_d   = raw_a_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            MDU_IDLE: begin
                if (issue) begin
                    case (bus.op)
                        MDU_MUL, MDU_DIV: begin
                            is_div_d  = (bus.op == MDU_DIV);
                            neg_d     = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            div0_d    = (bus.src_b == '0);
                            a_mag_d   = a_abs;
                            b_mag_d   = b_abs;
                            raw_a_d   = bus.src_a;
                            cnt_d     = CW'(WIDTH - 1);
`ifdef MDU_FAST_MUL_EN
                            state_d   = (bus.op == MDU_MUL) ? MDU_FIX : MDU_RUN;
`else
                            state_d   = MDU_RUN;
`endif
                        end
                        MDU_MTHI: hi_d = bus.src_a;
                        default:  lo_d = bus.src_a;
                    endcase
                end
            end
            MDU_RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = MDU_FIX;
            end
            MDU_FIX: begin
                state_d = MDU_IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = mul_res;
                end else if (div0_q) begin
                    hi_d = raw_a_q;
                    lo_d = '1;
                end else begin
                    // Most-negative / -1 falls out naturally: magnitude 2^(W-1) reads as most-negative.
                    lo_d = neg_q     ? ('0 - quo) : quo;
                    hi_d = neg_rem_q ? ('0 - rem) : rem;
                end
            end
            default: state_d = MDU_IDLE;
        endcase

        if (bus.flush && (state_q != MDU_IDLE)) begin
            state_d = MDU_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end

        busy_d = (state_d != MDU_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MDU_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            raw_a_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifndef MDU_FAST_MUL_EN
            prod_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            a_mag_q   <= a_mag_d;
            b_mag_q   <= b_mag_d;
            raw_a_q   <= raw_a_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifndef MDU_FAST_MUL_EN
            prod_q    <= prod_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
